// File: rtl/lift_req_queue.sv
// lift_req_queue
// Request-side producer for the lift controller FSM. Rising edges on the hall
// buttons become 3-bit request codes. A call whose lamp is already lit is
// dropped, so each code is in flight at most once. Accepted calls pass through
// a pending set and a lowest-index-first arbiter into a show-ahead FIFO. The
// FIFO head goes to the lift FSM on din/qEmpty.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active-high
//   btn_up   : UP hall buttons (level), bit0..2 = floor1..3
//   btn_dn   : DOWN hall buttons (level), bit0..2 = floor2..4
//   done     : lift FSM idle / ready to take din
//   din      : head request code, 000 when empty
//   qEmpty   : FIFO empty
//   q_full   : FIFO full
//   q_count  : entries held
//   lamp     : call-registered lamps, bit order 1U,2U,3U,2D,3D,4D
//
// Request index i (0..5) follows the lamp bit order.
// Code map: 1U=001 2U=010 3U=011 2D=110 3D=111 4D=100
module lift_req_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    btn_up,
  input  logic [2:0]    btn_dn,
  input  logic          done,
  output logic [2:0]    din,
  output logic          qEmpty,
  output logic          q_full,
  output logic [AW:0]   q_count,
  output logic [5:0]    lamp
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  function automatic logic [2:0] idx2code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b010;
      3'd2:    code = 3'b011;
      3'd3:    code = 3'b110;
      3'd4:    code = 3'b111;
      3'd5:    code = 3'b100;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] code2idx(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b001:  idx = 3'd0;
      3'b010:  idx = 3'd1;
      3'b011:  idx = 3'd2;
      3'b110:  idx = 3'd3;
      3'b111:  idx = 3'd4;
      3'b100:  idx = 3'd5;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  logic [5:0]    btn_vec;
  logic [5:0]    btn_q;
  logic [5:0]    pending_q, pending_d;
  logic [5:0]    queued_q, queued_d;
  logic          arm_q, arm_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    mem_q [DEPTH];

  logic [5:0]    press;
  logic          enq;
  logic          pop;
  logic [2:0]    enq_idx;
  logic [2:0]    head_code;

  assign btn_vec   = {btn_dn, btn_up};
  assign lamp      = pending_q | queued_q;
  assign qEmpty    = (count_q == '0);
  assign q_full    = (count_q == CNT_FULL);
  assign q_count   = count_q;
  assign head_code = mem_q[rptr_q];
  assign din       = qEmpty ? 3'b000 : head_code;

  // A lit lamp blocks a new press of the same call. This also covers a press
  // that lands in the same cycle as the pop of that code.
  assign press = btn_vec & ~btn_q & ~lamp;

  // Arm gives one pop per done-high interval. done stays high while the FSM
  // idles, so arm is only set again once done has dropped.
  assign pop = done & arm_q & ~qEmpty;
  assign enq = (pending_q != '0) & ~q_full;

  // Lowest-index pending bit wins. The loop runs downward so the lowest
  // set bit is the last assignment.
  always_comb begin
    enq_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_q[i]) enq_idx = 3'(i);
    end
  end

  always_comb begin
    pending_d = pending_q;
    queued_d  = queued_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    arm_d     = arm_q;

    // A pending and a queued copy of one code never coexist, so the enqueue
    // index and the popped index always differ.
    if (pop) begin
      queued_d[code2idx(head_code)] = 1'b0;
      rptr_d = rptr_q + PTR_ONE;
      arm_d  = 1'b0;
    end else if (!done) begin
      arm_d = 1'b1;
    end

    if (enq) begin
      pending_d[enq_idx] = 1'b0;
      queued_d[enq_idx]  = 1'b1;
      wptr_d = wptr_q + PTR_ONE;
    end

    pending_d = pending_d | press;

    case ({enq, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    btn_q <= btn_vec;
    if (rst) begin
      pending_q <= '0;
      queued_q  <= '0;
      arm_q     <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      queued_q  <= queued_d;
      arm_q     <= arm_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset. Entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!rst && enq) mem_q[wptr_q] <= idx2code(enq_idx);
  end

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed scenarios followed by random button/done/reset traffic. The
// reference model holds the calls as a queue of request indices.
module tb_lift_req_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  btn_up, btn_dn;
  logic        done;
  logic [2:0]  din;
  logic        qEmpty, q_full;
  logic [AW:0] q_count;
  logic [5:0]  lamp;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] m_btn_q;
  logic [5:0] m_pending;
  int         m_q[$];
  logic       m_arm;

  always #5 clk = ~clk;

  lift_req_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .done(done),
    .din(din), .qEmpty(qEmpty), .q_full(q_full), .q_count(q_count), .lamp(lamp)
  );

  function automatic logic [2:0] code_of(input int i);
    case (i)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b011;
      3: return 3'b110;
      4: return 3'b111;
      5: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [5:0] model_lamp();
    logic [5:0] l;
    l = m_pending;
    foreach (m_q[k]) l[m_q[k]] = 1'b1;
    return l;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs, take the edge, then compare.
  task automatic tick();
    logic [5:0] btnv, l, press;
    logic       pop, enq;
    int         idx;
    btnv = {btn_dn, btn_up};
    l    = model_lamp();
    press = btnv & ~m_btn_q & ~l;
    pop  = done && m_arm && (m_q.size() != 0);
    enq  = (m_pending != 0) && (m_q.size() < DEPTH);
    idx  = 0;
    for (int i = 5; i >= 0; i--) if (m_pending[i]) idx = i;
    @(posedge clk);
    m_btn_q = btnv;
    if (rst) begin
      m_pending = '0;
      m_q.delete();
      m_arm = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (enq) begin
        m_q.push_back(idx);
        m_pending[idx] = 1'b0;
      end
      m_pending = m_pending | press;
      if (pop) m_arm = 1'b0;
      else if (!done) m_arm = 1'b1;
    end
    #1;
    check("din",     {5'b0, din},       {5'b0, (m_q.size() != 0) ? code_of(m_q[0]) : 3'b000});
    check("qEmpty",  {7'b0, qEmpty},    {7'b0, m_q.size() == 0});
    check("q_full",  {7'b0, q_full},    {7'b0, m_q.size() == DEPTH});
    check("q_count", {4'b0, q_count},   8'(m_q.size()));
    check("lamp",    {2'b0, lamp},      {2'b0, model_lamp()});
  endtask

  initial begin
    m_btn_q = '0; m_pending = '0; m_arm = 1'b1;
    rst = 1'b1; done = 1'b0; btn_up = 3'b001; btn_dn = 3'b000;

    // 1: button held through reset produces no call
    tick(); tick();
    rst = 1'b0;
    tick();
    check("s1_lamp_after_rst", {2'b0, lamp}, 8'h00);
    check("s1_din_after_rst", {5'b0, din}, 8'h00);
    btn_up = 3'b000; tick();
    btn_up = 3'b001; tick();
    check("s1_lamp_press", {7'b0, lamp[0]}, 8'h01);
    btn_up = 3'b000; tick();
    check("s1_din", {5'b0, din}, 8'h01);
    check("s1_qEmpty", {7'b0, qEmpty}, 8'h00);
    done = 1'b1; tick();
    done = 1'b0; tick();

    // 2: three presses in one cycle drain in priority order
    btn_up = 3'b010; btn_dn = 3'b101; tick();
    btn_up = 3'b000; btn_dn = 3'b000;
    check("s2_lamp_pending", {2'b0, lamp}, 8'h2A);
    tick(); tick(); tick();
    check("s2_count", {4'b0, q_count}, 8'h03);
    check("s2_head", {5'b0, din}, 8'h02);
    check("s2_lamp", {2'b0, lamp}, 8'h2A);

    // 3: done held high pops once
    done = 1'b1;
    repeat (5) tick();
    check("s3_count", {4'b0, q_count}, 8'h02);
    check("s3_head", {5'b0, din}, 8'h06);
    check("s3_lamp", {2'b0, lamp}, 8'h28);
    done = 1'b0; tick();
    done = 1'b1; tick();
    check("s3_head2", {5'b0, din}, 8'h04);
    done = 1'b0; tick();
    done = 1'b1; tick();
    done = 1'b0; tick();

    // 4: duplicate 3U dropped, re-accepted after pop
    btn_up = 3'b100; tick(); btn_up = 3'b000; tick(); tick();
    btn_up = 3'b100; tick(); btn_up = 3'b000; tick(); tick();
    check("s4_dup_count", {4'b0, q_count}, 8'h01);
    done = 1'b1; tick(); done = 1'b0; tick();
    btn_up = 3'b100; tick(); btn_up = 3'b000; tick();
    check("s4_re_count", {4'b0, q_count}, 8'h01);
    check("s4_re_lamp", {2'b0, lamp}, 8'h04);
    done = 1'b1; tick(); done = 1'b0; tick();

    // 5: pop and enqueue on one edge; press of the code being popped
    btn_dn = 3'b001; tick(); btn_dn = 3'b000; tick();
    btn_up = 3'b001; tick();
    btn_up = 3'b000; done = 1'b1; tick();
    check("s5_count_same", {4'b0, q_count}, 8'h01);
    check("s5_head", {5'b0, din}, 8'h01);
    done = 1'b0; tick();
    done = 1'b1; tick(); done = 1'b0; tick();
    btn_dn = 3'b001; tick(); btn_dn = 3'b000; tick();
    btn_dn = 3'b001; done = 1'b1; tick();
    btn_dn = 3'b000; done = 1'b0; tick(); tick();
    check("s5_lamp_2d", {7'b0, lamp[3]}, 8'h00);
    check("s5_count_0", {4'b0, q_count}, 8'h00);

    // 6: reset discards queued and pending calls
    btn_up = 3'b111; btn_dn = 3'b001; tick();
    btn_up = 3'b000; btn_dn = 3'b000;
    repeat (4) tick();
    btn_dn = 3'b110; tick();
    btn_dn = 3'b000;
    check("s6_count_pre", {4'b0, q_count}, 8'h04);
    rst = 1'b1; tick(); rst = 1'b0;
    check("s6_count", {4'b0, q_count}, 8'h00);
    check("s6_lamp", {2'b0, lamp}, 8'h00);
    check("s6_din", {5'b0, din}, 8'h00);
    done = 1'b1;
    repeat (3) tick();
    btn_up = 3'b001; tick(); btn_up = 3'b000; tick(); tick();
    check("s6_arm_pop", {4'b0, q_count}, 8'h00);
    done = 1'b0; tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) btn_up[b] = ~btn_up[b];
        if ($urandom_range(0, 5) == 0) btn_dn[b] = ~btn_dn[b];
      end
      if ($urandom_range(0, 2) == 0) done = ~done;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lift_req_queue.md
Name: lift_req_queue

Overview:
- Request-side producer for the lift controller FSM.
- Captures hall-call button presses and encodes each one into the 3-bit lift request code.
- Drops duplicate calls, buffers accepted calls in a show-ahead FIFO, and presents the head as din/qEmpty to the lift FSM.
- Pops one entry each time the FSM signals done.

Parameters:
- DEPTH, 8: FIFO entries. Must be a power of two and at least 6.
- AW, 3: pointer width, log2(DEPTH).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- btn_up, input, 3: level hall buttons UP; bit0 = floor1, bit1 = floor2, bit2 = floor3.
- btn_dn, input, 3: level hall buttons DOWN; bit0 = floor2, bit1 = floor3, bit2 = floor4.
- done, input, 1: from lift FSM; high when the FSM is idle and ready to take din.
- din, output, 3: head request code; 000 when empty.
- qEmpty, output, 1: FIFO empty.
- q_full, output, 1: FIFO full.
- q_count, output, AW+1: entries held.
- lamp, output, 6: call-registered lamps; bit order 1U, 2U, 3U, 2D, 3D, 4D.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Request codes:
  - 1U = 001, 2U = 010, 3U = 011
  - 2D = 110, 3D = 111, 4D = 100
  - none = 000
- Request index i = 0..5 maps to lamp order: {btn_up[0], btn_up[1], btn_up[2], btn_dn[0], btn_dn[1], btn_dn[2]}.
- Reset:
  - pending = 0, FIFO flushed (ptrs = 0, count = 0), arm = 1.
  - Edge-detect registers load the current button levels, so a button held through reset does not produce a call.
  - Outputs after reset: din = 000, qEmpty = 1, q_full = 0, q_count = 0, lamp = 0.
  - Reset mid-operation discards all pending and queued calls.
- Press detect:
  - press[i] = btn[i] & ~btn_q[i]; btn_q is registered every cycle.
  - A press is accepted only if lamp[i] = 0 at that cycle. Otherwise it is ignored: no duplicates, including a press in the same cycle as a pop of the same code.
  - Accepted press sets pending[i] at the clock edge.
- Enqueue arbiter:
  - Each cycle, if pending != 0 and q_full = 0, the lowest-index set pending bit is written at wptr.
  - That pending bit is cleared; wptr and count are incremented.
  - One enqueue per cycle. When full, pending bits are held (no loss).
- Queued-flag tracking:
  - queued[i] is set on enqueue of code i and cleared on pop of code i.
  - lamp = pending | queued.
  - With dedup, at most 6 codes are in flight, so with DEPTH ≥ 6, full never blocks in practice. Full handling is still required.
- Pop handshake:
  - pop = done & arm & ~qEmpty.
  - On pop: rptr and count are decremented/advanced, queued[head] is cleared, arm is cleared.
  - arm is set again in any cycle where done = 0.
  - Result: at most one pop per contiguous done-high interval, even though done stays high while the FSM sits idle.
- Output timing:
  - din = mem[rptr] when count > 0, else 000. It is combinational from registers and stable for the whole cycle.
  - Latency: press sampled in cycle N → lamp high in N+1 → enqueued at the end of N+1 (if highest priority) → qEmpty = 0 and din valid from N+2.
  - Pop in cycle M → next head on din from M+1.
- Simultaneous enqueue and pop: both take effect; count unchanged. Pointers wrap modulo DEPTH.
- Multiple presses in one cycle: all set pending and drain in priority order, one per cycle.
- q_full = (count == DEPTH). qEmpty = (count == 0).

Test Plan:
1. Reset with btn_up[0] held high, release rst → lamp = 0, qEmpty = 1, din = 000. Then drop and re-press btn_up[0] → lamp[0] = 1 next cycle; din = 001, qEmpty = 0 two cycles after the press.
2. In one cycle, press btn_dn[2] (4D), btn_up[1] (2U), btn_dn[0] (2D), with done = 0 → FIFO order 010, 110, 100; q_count reaches 3; lamp = 101010b.
3. Hold done = 1 for 5 cycles with 3 entries queued → exactly one pop (din 010 → 110, q_count 3 → 2, lamp[1] cleared). Then done = 0 for 1 cycle and high again → second pop, din = 100.
4. Press 3U twice (release between presses) while 3U is queued → single entry; q_count stays 1. Pop 3U, then press 3U again → re-accepted, q_count = 1, lamp[2] = 1.
5. Same-cycle pop of 2D and press of a new 1U → q_count unchanged at the enqueue edge. Also press 2D in the same cycle that 2D is popped → press ignored; lamp[3] = 0 afterwards.
6. Assert rst for 1 cycle with 4 entries queued and 2 pending → next cycle q_count = 0, lamp = 0, din = 000, arm = 1; queued codes are never delivered.
